// File: rtl/iram_arb.sv
// Two-master arbiter (core m0, debug/loader m1) for the single-port iram.
// Latency: grant is combinational in the request cycle; rvalid/rdata follow one cycle after accept.
// Backpressure: a master holds req until gnt; m1 lock and starvation timeout decide who waits.
module iram_arb #(
   parameter int AW       = 15,
   parameter bit RR_EN    = 1'b1,
   parameter int WAIT_MAX = 15
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          m0_req,
   input  logic [3:0]    m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,

   input  logic          m1_req,
   input  logic [3:0]    m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,

   output logic          sram_en,
   output logic [3:0]    sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   input  logic [31:0]   sram_rdata
);

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      LOCK1 = 1'b1
   } state_t;

   localparam logic [7:0] WMAX = 8'(WAIT_MAX);

   state_t      state_q, state_d;
   logic        last_q;            // 1: m1 owned the most recent transfer
   logic [7:0]  wait0_q, wait1_q;
   logic        starve0, starve1;
   logic        gnt0, gnt1;
   logic        rv0_q, rv1_q, rd_q;
   logic [31:0] hold0_q, hold1_q;

   assign starve0 = m0_req && (wait0_q == WMAX);
   assign starve1 = m1_req && (wait1_q == WMAX);

   // Starvation overrides lock and priority; a double starvation falls back to round-robin.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (starve0 && starve1) begin
         if (last_q) gnt0 = 1'b1;
         else        gnt1 = 1'b1;
      end else if (starve0) begin
         gnt0 = 1'b1;
      end else if (starve1) begin
         gnt1 = 1'b1;
      end else if (state_q == LOCK1) begin
         gnt1 = m1_req;
      end else if (m0_req && m1_req) begin
         if (RR_EN && !last_q) gnt1 = 1'b1;
         else                  gnt0 = 1'b1;
      end else begin
         gnt0 = m0_req;
         gnt1 = m1_req;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB: begin
            if (gnt1 && m1_lock) state_d = LOCK1;
         end
         LOCK1: begin
            if (gnt0 || (gnt1 && !m1_lock) || (!m1_req && !m1_lock)) state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   assign m0_gnt     = gnt0;
   assign m1_gnt     = gnt1;
   assign sram_en    = gnt0 | gnt1;
   assign sram_we    = gnt0 ? m0_we    : (gnt1 ? m1_we    : 4'd0);
   assign sram_addr  = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
   assign sram_wdata = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : 32'd0);

   // Read data comes straight from the macro in the completion cycle; writes keep the last value.
   assign m0_rvalid = rv0_q;
   assign m1_rvalid = rv1_q;
   assign m0_rdata  = (rv0_q && rd_q) ? sram_rdata : hold0_q;
   assign m1_rdata  = (rv1_q && rd_q) ? sram_rdata : hold1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB;
         last_q  <= 1'b1;
         wait0_q <= 8'd0;
         wait1_q <= 8'd0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         rd_q    <= 1'b0;
         hold0_q <= 32'd0;
         hold1_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (gnt0)      last_q <= 1'b0;
         else if (gnt1) last_q <= 1'b1;

         if (!m0_req || gnt0)     wait0_q <= 8'd0;
         else if (wait0_q < WMAX) wait0_q <= wait0_q + 8'd1;
         if (!m1_req || gnt1)     wait1_q <= 8'd0;
         else if (wait1_q < WMAX) wait1_q <= wait1_q + 8'd1;

         rv0_q   <= gnt0;
         rv1_q   <= gnt1;
         rd_q    <= sram_en && (sram_we == 4'd0);
         hold0_q <= m0_rdata;
         hold1_q <= m1_rdata;
      end
   end

   a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(m0_gnt && m1_gnt));
   a_lock_blocks_m0: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == LOCK1 && m0_gnt) |-> starve0);

endmodule

// File: tb/tb_iram_arb.sv
// Scoreboard bench for iram_arb: three instances (RR/15, fixed/3, RR/2), each with its own SRAM model.
module tb_iram_arb;
   localparam int AW = 15;
   localparam int NW = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_clr = 1'b1;
   int            cur_k = 0;

   logic          m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
   logic [3:0]    m0_we = 4'd0, m1_we = 4'd0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [31:0]   m0_wdata = 32'd0, m1_wdata = 32'd0;

   logic          g0 [3];
   logic          g1 [3];
   logic          rv0 [3];
   logic          rv1 [3];
   logic          se [3];
   logic [31:0]   rd0 [3];
   logic [31:0]   rd1 [3];

   typedef struct {
      logic        m;
      logic        rd;
      logic [31:0] data;
   } rsp_t;

   rsp_t          sb_q [$];
   logic [31:0]   shadow [3][NW];
   logic [31:0]   exp_rd [2];
   int            n_chk = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [AW-1:0] a);
      return (a == AW'('h10)) ? 32'hDEADBEEF : (32'h5A5A_0000 + 32'(a));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] wd,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = base;
      for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   for (genvar i = 0; i < 3; i++) begin : g_dut
      logic [3:0]    swe;
      logic [AW-1:0] sa;
      logic [31:0]   swd;
      logic [31:0]   srd;
      logic [31:0]   mem [NW];
      logic [NW-1:0] wr_mask;

      iram_arb #(
         .AW       (AW),
         .RR_EN    ((i == 1) ? 1'b0 : 1'b1),
         .WAIT_MAX ((i == 0) ? 15 : ((i == 1) ? 3 : 2))
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .m0_req     (m0_req && (cur_k == i)),
         .m0_we      (m0_we),
         .m0_addr    (m0_addr),
         .m0_wdata   (m0_wdata),
         .m0_gnt     (g0[i]),
         .m0_rvalid  (rv0[i]),
         .m0_rdata   (rd0[i]),
         .m1_req     (m1_req && (cur_k == i)),
         .m1_we      (m1_we),
         .m1_addr    (m1_addr),
         .m1_wdata   (m1_wdata),
         .m1_lock    (m1_lock && (cur_k == i)),
         .m1_gnt     (g1[i]),
         .m1_rvalid  (rv1[i]),
         .m1_rdata   (rd1[i]),
         .sram_en    (se[i]),
         .sram_we    (swe),
         .sram_addr  (sa),
         .sram_wdata (swd),
         .sram_rdata (srd)
      );

      always @(posedge clk) begin
         if (mem_clr) begin
            wr_mask <= '0;
         end else if (se[i]) begin
            if (swe == 4'd0) begin
               srd <= wr_mask[sa] ? mem[sa] : init_val(sa);
            end else begin
               mem[sa]     <= merge(wr_mask[sa] ? mem[sa] : init_val(sa), swd, swe);
               wr_mask[sa] <= 1'b1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s (inst %0d): got 0x%08h expected 0x%08h", tag, cur_k, got, exp);
   endtask

   // One clock: check completions/grants at negedge, push what this cycle should complete.
   task automatic step(input logic e0, input logic e1);
      rsp_t r;
      @(negedge clk);
      if (sb_q.size() > 0) begin
         r = sb_q.pop_front();
         check("rvalid0", 32'(rv0[cur_k]), 32'(r.m == 1'b0));
         check("rvalid1", 32'(rv1[cur_k]), 32'(r.m == 1'b1));
         if (r.rd) exp_rd[r.m] = r.data;
      end else begin
         check("rvalid0_idle", 32'(rv0[cur_k]), 32'd0);
         check("rvalid1_idle", 32'(rv1[cur_k]), 32'd0);
      end
      check("rdata0", rd0[cur_k], exp_rd[0]);
      check("rdata1", rd1[cur_k], exp_rd[1]);
      check("gnt0", 32'(g0[cur_k]), 32'(e0));
      check("gnt1", 32'(g1[cur_k]), 32'(e1));
      check("sram_en", 32'(se[cur_k]), 32'(e0 | e1));
      if (e0) begin
         r.m    = 1'b0;
         r.rd   = (m0_we == 4'd0);
         r.data = shadow[cur_k][m0_addr];
         if (!r.rd) shadow[cur_k][m0_addr] = merge(shadow[cur_k][m0_addr], m0_wdata, m0_we);
         sb_q.push_back(r);
      end else if (e1) begin
         r.m    = 1'b1;
         r.rd   = (m1_we == 4'd0);
         r.data = shadow[cur_k][m1_addr];
         if (!r.rd) shadow[cur_k][m1_addr] = merge(shadow[cur_k][m1_addr], m1_wdata, m1_we);
         sb_q.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      m0_req  = 1'b0;
      m1_req  = 1'b0;
      m1_lock = 1'b0;
      sb_q.delete();
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      @(negedge clk);
      check("rst_rvalid0", 32'(rv0[cur_k]), 32'd0);
      check("rst_rvalid1", 32'(rv1[cur_k]), 32'd0);
      check("rst_rdata0", rd0[cur_k], 32'd0);
      check("rst_rdata1", rd1[cur_k], 32'd0);
      check("rst_gnt0", 32'(g0[cur_k]), 32'd0);
      check("rst_gnt1", 32'(g1[cur_k]), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drive_m0(input logic req, input logic [3:0] we, input int addr, input logic [31:0] wd);
      m0_req = req; m0_we = we; m0_addr = AW'(addr); m0_wdata = wd;
   endtask

   task automatic drive_m1(input logic req, input logic [3:0] we, input int addr, input logic [31:0] wd,
                           input logic lock);
      m1_req = req; m1_we = we; m1_addr = AW'(addr); m1_wdata = wd; m1_lock = lock;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++)
         for (int a = 0; a < NW; a++) shadow[k][a] = init_val(AW'(a));
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cur_k = k;
         do_reset();
      end

      // single master read of 0x10
      cur_k = 0;
      do_reset();
      drive_m0(1'b1, 4'd0, 'h10, 32'd0);
      step(1'b1, 1'b0);
      m0_req = 1'b0;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // round-robin conflict straight after reset: m0 first
      do_reset();
      drive_m0(1'b1, 4'd0, 1, 32'd0);
      drive_m1(1'b1, 4'd0, 2, 32'd0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      m0_req = 1'b0; m1_req = 1'b0;
      step(1'b0, 1'b0);

      // fixed priority with WAIT_MAX=3: m1 is forced in on the 4th cycle
      cur_k = 1;
      do_reset();
      drive_m0(1'b1, 4'd0, 1, 32'd0);
      drive_m1(1'b1, 4'b0011, 5, 32'h1122_3344, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      m1_req  = 1'b0;
      m0_addr = AW'(5);
      step(1'b1, 1'b0);
      m0_req = 1'b0;
      step(1'b0, 1'b0);

      // m1 locked burst, including a req-less locked gap; then read the burst back
      cur_k = 0;
      do_reset();
      drive_m0(1'b1, 4'd0, 7, 32'd0);
      step(1'b1, 1'b0);
      drive_m1(1'b1, 4'hF, 0, 32'hCAFE_0000, 1'b1);
      step(1'b0, 1'b1);
      drive_m1(1'b1, 4'hF, 1, 32'hCAFE_0001, 1'b1);
      step(1'b0, 1'b1);
      m1_req = 1'b0;
      step(1'b0, 1'b0);
      drive_m1(1'b1, 4'hF, 2, 32'hCAFE_0002, 1'b1);
      step(1'b0, 1'b1);
      drive_m1(1'b1, 4'hF, 3, 32'hCAFE_0003, 1'b0);
      step(1'b0, 1'b1);
      m1_req = 1'b0;
      step(1'b1, 1'b0);
      for (int a = 0; a < 4; a++) begin
         m0_addr = AW'(a);
         step(1'b1, 1'b0);
      end
      m0_req = 1'b0;
      step(1'b0, 1'b0);

      // starvation breaks the lock with WAIT_MAX=2, and the FSM is back in ARB
      cur_k = 2;
      do_reset();
      drive_m1(1'b1, 4'hF, 8, 32'hB0B0_0008, 1'b1);
      step(1'b0, 1'b1);
      drive_m0(1'b1, 4'd0, 'h10, 32'd0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      m1_req = 1'b0;
      step(1'b1, 1'b0);
      m0_req = 1'b0; m1_lock = 1'b0;
      step(1'b0, 1'b0);

      // reset right after a read accept discards the completion
      cur_k = 0;
      do_reset();
      drive_m0(1'b1, 4'd0, 'h10, 32'd0);
      step(1'b1, 1'b0);
      do_reset();
      drive_m0(1'b1, 4'd0, 'h10, 32'd0);
      step(1'b1, 1'b0);
      m0_req = 1'b0;
      step(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
